sipo_deser: RTL and testbench

SIPO_DESER -- requirements
Module: sipo_deser

---
 rtl/sipo_deser.sv | 102 ++++++++++
 tb/tb_sipo_deser.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserializer with registered word output and overrun flag.
// Define SIPO_DESER_PARITY_EN to append one even-parity bit to each frame.
module sipo_deser #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       in_bit,
  input  logic                       clear,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
  output logic                       overrun,
  output logic                       parity_err
);

  localparam int CW = $clog2(WIDTH + 1);
`ifdef SIPO_DESER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_over;
  logic             r_par;

  logic             w_take;
  logic             w_last;
  logic             w_load;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_word;
  logic             w_par;

  assign w_take = in_valid & ~clear;
  assign w_last = w_take & (r_cnt == LAST);
  assign w_load = w_last & (~r_valid | out_ready);

  assign w_shifted = (MSB_FIRST != 0)
                   ? {r_shift[WIDTH-2:0], in_bit}
                   : {in_bit, r_shift[WIDTH-1:1]};

`ifdef SIPO_DESER_PARITY_EN
  // Parity bit is the final frame bit; it is checked, never shifted in.
  assign w_word = r_shift;
  assign w_par  = (^r_shift) ^ in_bit;
`else
  assign w_word = w_shifted;
  assign w_par  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (w_take) begin
      if (w_last) begin
        r_shift <= '0;
        r_cnt   <= '0;
      end else begin
        r_shift <= w_shifted;
        r_cnt   <= r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_par   <= 1'b0;
    end else if (w_load) begin
      r_data  <= w_word;
      r_valid <= 1'b1;
      r_par   <= w_par;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_over <= 1'b0;
    end else if (w_last && r_valid && !out_ready) begin
      r_over <= 1'b1;
    end
  end

  assign out_data   = r_data;
  assign out_valid  = r_valid;
  assign bit_cnt    = r_cnt;
  assign overrun    = r_over;
  assign parity_err = r_par;

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: MSB-first and LSB-first instances against a
// bit-queue reference model, plus directed literal scenarios.
module tb_sipo_deser;

  localparam int W = 8;
`ifdef SIPO_DESER_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_bit = 1'b0;
  logic clear = 1'b0;
  logic out_ready = 1'b0;

  logic [W-1:0] d1, d0;
  logic         v1, v0;
  logic [3:0]   c1, c0;
  logic         o1, o0;
  logic         p1, p0;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .clear(clear), .out_ready(out_ready), .out_data(d1),
    .out_valid(v1), .bit_cnt(c1), .overrun(o1), .parity_err(p1)
  );

  sipo_deser #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .clear(clear), .out_ready(out_ready), .out_data(d0),
    .out_valid(v0), .bit_cnt(c0), .overrun(o0), .parity_err(p0)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame bits collected in arrival order.
  bit          q[$];
  logic [31:0] m_w1, m_w0;
  logic        m_valid, m_par, m_over;

  initial begin
    m_w1 = '0; m_w0 = '0;
    m_valid = 1'b0; m_par = 1'b0; m_over = 1'b0;
  end

  always @(posedge clk) begin
    bit          done;
    logic [31:0] n1, n0;
    logic        np;
    done = 1'b0; n1 = '0; n0 = '0; np = 1'b0;
    if (rst) begin
      q.delete();
      m_w1 = '0; m_w0 = '0;
      m_valid = 1'b0; m_par = 1'b0; m_over = 1'b0;
    end else begin
      if (clear) begin
        q.delete();
        m_over = 1'b0;
      end else if (in_valid) begin
        q.push_back(in_bit);
        if (q.size() == FRAME) begin
          for (int i = 0; i < W; i++) begin
            n1 = (n1 << 1) | 32'(q[i]);
            n0 = n0 | (32'(q[i]) << i);
          end
          for (int i = 0; i < FRAME; i++) np = np ^ q[i];
`ifndef SIPO_DESER_PARITY_EN
          np = 1'b0;
`endif
          done = 1'b1;
          q.delete();
        end
      end
      if (done && (!m_valid || out_ready)) begin
        m_w1 = n1; m_w0 = n0; m_par = np; m_valid = 1'b1;
      end else if (done) begin
        m_over = 1'b1;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_data", 32'(d1), m_w1);
      chk("l_data", 32'(d0), m_w0);
      chk("m_valid", 32'(v1), 32'(m_valid));
      chk("l_valid", 32'(v0), 32'(m_valid));
      chk("m_cnt", 32'(c1), 32'(q.size()));
      chk("l_cnt", 32'(c0), 32'(q.size()));
      chk("m_over", 32'(o1), 32'(m_over));
      chk("l_over", 32'(o0), 32'(m_over));
      chk("m_par", 32'(p1), 32'(m_par));
      chk("l_par", 32'(p0), 32'(m_par));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends n bits of seq, seq[n-1] first; out_ready raised on the last bit if asked.
  task automatic send_seq(input logic [31:0] seq, input int n,
                          input bit rdy_last);
    for (int i = n - 1; i >= 0; i--) begin
      in_valid = 1'b1;
      in_bit   = seq[i];
      if (rdy_last) out_ready = (i == 0);
      step();
    end
    in_valid = 1'b0;
    if (rdy_last) out_ready = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input bit rdy_last);
`ifdef SIPO_DESER_PARITY_EN
    send_seq({23'd0, w, ^w}, 9, rdy_last);
`else
    send_seq({24'd0, w}, 8, rdy_last);
`endif
  endtask

  initial begin
    rst = 1'b1;
    step(); step();
    chk("rst_valid", 32'(v1), 0);
    chk("rst_data", 32'(d1), 0);
    chk("rst_cnt", 32'(c1), 0);
    chk("rst_over", 32'(o1), 0);
    chk("rst_par", 32'(p1), 0);
    rst = 1'b0;
    cmp_en = 1'b1;

    out_ready = 1'b1;
    send_word(8'hC0, 1'b0);
    chk("c0_valid", 32'(v1), 1);
    chk("c0_msb", 32'(d1), 32'h0C0);
    chk("c0_lsb", 32'(d0), 32'h003);
    step();
    chk("c0_once", 32'(v1), 0);

    out_ready = 1'b0;
    send_word(8'hA5, 1'b0);
    send_word(8'h3C, 1'b0);
    chk("ovr_data", 32'(d1), 32'h0A5);
    chk("ovr_flag", 32'(o1), 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_over", 32'(o1), 0);
    chk("clr_valid", 32'(v1), 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    send_seq(32'h1F, 5, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_cnt", 32'(c1), 0);
    send_word(8'h81, 1'b0);
    chk("rst_mid_data", 32'(d1), 32'h081);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b1);
    chk("b2b_valid", 32'(v1), 1);
    chk("b2b_data", 32'(d1), 32'h022);
    chk("b2b_over", 32'(o1), 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

`ifdef SIPO_DESER_PARITY_EN
    send_seq({23'd0, 8'h07, 1'b1}, 9, 1'b1);
    chk("par_ok", 32'(p1), 0);
    send_seq({23'd0, 8'h07, 1'b0}, 9, 1'b1);
    chk("par_bad", 32'(p1), 1);
    out_ready = 1'b1;
    step();
`endif

    repeat (3000) begin
      rst       = ($urandom_range(0, 299) == 0);
      clear     = ($urandom_range(0, 39) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_bit    = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
